// File: rtl/st7735_bus_arbiter.sv
// Arbitrates the ST7735 SPI byte serializer between a command channel and a pixel stream,
// owning CS framing, per-byte D/C and RAMWR/RAMWRC insertion. Optional macro: ST7735_ARB_BURST_LIMIT_EN.
module st7735_bus_arbiter #(
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2,
    parameter int CS_GAP_CYCLES   = 4,
    parameter int MAX_PIX_BURST   = 256
) (
    input  logic       SYSTEM_CLK,
    input  logic       RST_N,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    input  logic       cmd_dc,
    input  logic       cmd_last,
    output logic       cmd_ready,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    input  logic       pix_first,
    input  logic       pix_last,
    output logic       pix_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    input  logic       tx_ready,
    input  logic       tx_idle,
    output logic       LCD_CS,
    output logic [1:0] grant,
    output logic       err
);

    localparam int MAX_CS = (CS_SETUP_CYCLES > CS_HOLD_CYCLES)
                          ? ((CS_SETUP_CYCLES > CS_GAP_CYCLES) ? CS_SETUP_CYCLES : CS_GAP_CYCLES)
                          : ((CS_HOLD_CYCLES  > CS_GAP_CYCLES) ? CS_HOLD_CYCLES  : CS_GAP_CYCLES);
    localparam int CW = $clog2(MAX_CS + 1) + 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'((CS_SETUP_CYCLES > 0) ? CS_SETUP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] HOLD_LAST  = CW'((CS_HOLD_CYCLES  > 0) ? CS_HOLD_CYCLES  - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST   = CW'((CS_GAP_CYCLES   > 0) ? CS_GAP_CYCLES   - 1 : 0);

    localparam logic [1:0] GRANT_CMD = 2'b01;
    localparam logic [1:0] GRANT_PIX = 2'b10;

    if ((MAX_PIX_BURST < 2) || ((MAX_PIX_BURST % 2) != 0)) begin : g_bad_burst
        $error("MAX_PIX_BURST must be a positive even number");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PREFIX, S_STREAM, S_DRAIN, S_HOLD, S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_grant;
    logic            r_frame_open;
    logic            r_pfx_start;
    logic [CW-1:0]   r_cnt;

    logic [1:0]      w_latch;
    logic            w_fo_set;
    logic            w_fo_clr;
    logic            w_pix_acc;
    logic            w_yield;

`ifdef ST7735_ARB_BURST_LIMIT_EN
    localparam int BW = $clog2(MAX_PIX_BURST) + 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_PIX_BURST - 1);

    logic [BW-1:0] r_burst_cnt;
    logic          r_odd;

    // Yield only after the second byte of a pixel so the resumed stream stays aligned.
    assign w_yield = cmd_valid && r_odd && (r_burst_cnt >= BURST_LAST);

    always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_burst_cnt <= '0;
            r_odd       <= 1'b0;
        end else if (w_latch != 2'b00) begin
            r_burst_cnt <= '0;
            r_odd       <= 1'b0;
        end else if (w_pix_acc) begin
            r_odd <= ~r_odd;
            if (r_burst_cnt != '1) r_burst_cnt <= r_burst_cnt + BW'(1);
        end
    end
`else
    assign w_yield = 1'b0;
`endif

    assign grant = r_grant;

    always_comb begin
        w_next    = r_state;
        w_latch   = 2'b00;
        w_fo_set  = 1'b0;
        w_fo_clr  = 1'b0;
        w_pix_acc = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_dc     = 1'b1;
        cmd_ready = 1'b0;
        pix_ready = 1'b0;
        LCD_CS    = 1'b1;
        err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_latch = GRANT_CMD;
                    w_next  = S_SETUP;
                end else if (pix_valid) begin
                    if (pix_first || r_frame_open) begin
                        w_latch = GRANT_PIX;
                        w_next  = S_SETUP;
                    end else begin
                        pix_ready = 1'b1;
                        err       = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                LCD_CS = 1'b0;
                if (r_cnt >= SETUP_LAST)
                    w_next = (r_grant == GRANT_CMD) ? S_STREAM : S_PREFIX;
            end
            S_PREFIX: begin
                LCD_CS   = 1'b0;
                tx_valid = 1'b1;
                tx_dc    = 1'b0;
                tx_data  = r_pfx_start ? 8'h2C : 8'h3C;
                if (tx_ready) begin
                    w_fo_set = 1'b1;
                    w_next   = S_STREAM;
                end
            end
            S_STREAM: begin
                LCD_CS = 1'b0;
                if (r_grant == GRANT_CMD) begin
                    tx_valid  = cmd_valid;
                    tx_data   = cmd_data;
                    tx_dc     = cmd_dc;
                    cmd_ready = tx_ready & cmd_valid;
                    if (cmd_ready && cmd_last) w_next = S_DRAIN;
                end else begin
                    tx_valid  = pix_valid;
                    tx_data   = pix_data;
                    tx_dc     = 1'b1;
                    pix_ready = tx_ready & pix_valid;
                    w_pix_acc = pix_ready;
                    if (pix_ready && pix_last) begin
                        w_fo_clr = 1'b1;
                        w_next   = S_DRAIN;
                    end else if (pix_ready && w_yield) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                LCD_CS = 1'b0;
                if (tx_idle) w_next = S_HOLD;
            end
            S_HOLD: begin
                LCD_CS = 1'b0;
                if (r_cnt >= HOLD_LAST) w_next = S_GAP;
            end
            S_GAP: begin
                if (r_cnt >= GAP_LAST) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_frame_open <= 1'b0;
            r_pfx_start  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != w_next)
                r_cnt <= '0;
            else if (r_cnt != '1)
                r_cnt <= r_cnt + CW'(1);
            if (w_latch != 2'b00)
                r_grant <= w_latch;
            else if ((r_state == S_GAP) && (w_next == S_IDLE))
                r_grant <= '0;
            if (w_latch == GRANT_PIX)
                r_pfx_start <= pix_first;
            if (w_fo_clr)
                r_frame_open <= 1'b0;
            else if (w_fo_set)
                r_frame_open <= 1'b1;
        end
    end

endmodule

// File: tb/tb_st7735_bus_arbiter.sv
// Randomized self-checking bench: a serializer model and a byte/CS monitor feed a queue-based
// reference of the expected byte stream; directed cases cover framing timing, priority, errors and reset.
module tb_st7735_bus_arbiter;

    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int GAP   = 4;
`ifdef ST7735_ARB_BURST_LIMIT_EN
    localparam int MAXB = 4;
`else
    localparam int MAXB = 256;
`endif

    logic       SYSTEM_CLK = 1'b0;
    logic       RST_N;
    logic       cmd_valid, cmd_dc, cmd_last, cmd_ready;
    logic [7:0] cmd_data;
    logic       pix_valid, pix_first, pix_last, pix_ready;
    logic [7:0] pix_data;
    logic       tx_valid, tx_dc, tx_ready, tx_idle;
    logic [7:0] tx_data;
    logic       LCD_CS, err;
    logic [1:0] grant;

    st7735_bus_arbiter #(
        .CS_SETUP_CYCLES(SETUP), .CS_HOLD_CYCLES(HOLD),
        .CS_GAP_CYCLES(GAP), .MAX_PIX_BURST(MAXB)
    ) dut (
        .SYSTEM_CLK(SYSTEM_CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_dc(cmd_dc), .cmd_last(cmd_last),
        .cmd_ready(cmd_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_first(pix_first), .pix_last(pix_last),
        .pix_ready(pix_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_dc(tx_dc), .tx_ready(tx_ready), .tx_idle(tx_idle),
        .LCD_CS(LCD_CS), .grant(grant), .err(err)
    );

    always #5 SYSTEM_CLK = ~SYSTEM_CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference stream: {dc, byte} for every byte the serializer should accept, in order.
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [1:0] win_grant_q[$];
    int windows = 0, err_cnt = 0, pix_sent = 0;
    int setup_cnt, post, gap_cnt = 0, setup_last, hold_last, gap_last;
    bit in_win = 0, seen_tx = 0, acc_flag = 0;
    int mode = 0, busy_max = 0, busy = 0;

    always @(negedge SYSTEM_CLK) begin
        if (!RST_N) begin
            in_win = 0;
            gap_cnt = 0;
        end else begin
            if (err) err_cnt++;
            if (!LCD_CS) begin
                if (!in_win) begin
                    in_win = 1; windows++; setup_cnt = 0; seen_tx = 0; post = 0;
                    gap_last = gap_cnt;
                end
                if (tx_valid && !seen_tx) begin
                    seen_tx = 1;
                    win_grant_q.push_back(grant);
                end else if (!seen_tx) setup_cnt++;
                if (tx_valid && tx_ready) post = 0;
                else post++;
            end else begin
                if (in_win) begin
                    in_win = 0; setup_last = setup_cnt; hold_last = post; gap_cnt = 0;
                end
                gap_cnt++;
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back({tx_dc, tx_data});
                acc_flag = 1;
            end
        end
    end

    // Serializer model: ready pattern by mode, shift-busy time after each accepted byte.
    always begin
        @(posedge SYSTEM_CLK);
        #1;
        if (acc_flag) busy = $urandom_range(busy_max, 0);
        else if (busy > 0) busy--;
        acc_flag = 0;
        tx_idle = (busy == 0);
        case (mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(1, 0));
        endcase
    end

    task automatic send_byte(input bit is_pix, input logic [7:0] d, input logic flag,
                             input logic last, output logic e);
        bit ok = 0;
        logic rdy;
        e = 1'b0;
        if (is_pix) begin
            pix_valid = 1; pix_data = d; pix_first = flag; pix_last = last;
        end else begin
            cmd_valid = 1; cmd_data = d; cmd_dc = flag; cmd_last = last;
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge SYSTEM_CLK);
            rdy = is_pix ? pix_ready : cmd_ready;
            if (rdy) begin
                ok = 1;
                e = err;
                break;
            end
        end
        if (!ok) check(is_pix ? "pix_ready_timeout" : "cmd_ready_timeout", 32'(ok), 32'd1);
        @(posedge SYSTEM_CLK);
        #1;
        if (is_pix) begin
            pix_valid = 0; pix_sent++;
        end else cmd_valid = 0;
    endtask

    task automatic idle_gap(input bit rnd);
        int n = rnd ? $urandom_range(2, 0) : 0;
        repeat (n) begin
            @(posedge SYSTEM_CLK);
            #1;
        end
    endtask

    task automatic send_cmd(input int n, input logic [7:0] b[16], input bit rnd);
        logic e;
        for (int i = 0; i < n; i++) begin
            send_byte(0, b[i], (i != 0), (i == n - 1), e);
            if (i != n - 1) idle_gap(rnd);
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] b[16], input bit rnd);
        logic e;
        for (int i = 0; i < n; i++) begin
            send_byte(1, b[i], (i == 0), (i == n - 1), e);
            if (i != n - 1) idle_gap(rnd);
        end
    endtask

    task automatic exp_cmd(input int n, input logic [7:0] b[16]);
        for (int i = 0; i < n; i++) exp_q.push_back({(i != 0), b[i]});
    endtask

    task automatic exp_frame(input int lo, input int hi, input logic [7:0] b[16], input logic [7:0] pfx);
        exp_q.push_back({1'b0, pfx});
        for (int i = lo; i < hi; i++) exp_q.push_back({1'b1, b[i]});
    endtask

    task automatic wait_quiet();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge SYSTEM_CLK);
            if (LCD_CS && !in_win) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("cs_release_timeout", 32'(ok), 32'd1);
        repeat (GAP + 2) @(posedge SYSTEM_CLK);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    logic [7:0] b[16];
    logic [7:0] c[16];
    logic e;
    int w0, e0, n, base;

    initial begin
        RST_N = 0;
        cmd_valid = 0; cmd_data = '0; cmd_dc = 0; cmd_last = 0;
        pix_valid = 0; pix_data = '0; pix_first = 0; pix_last = 0;
        tx_ready = 1; tx_idle = 1;
        repeat (3) @(posedge SYSTEM_CLK);
        #1;
        check("rst_cs", 32'(LCD_CS), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_dc", 32'(tx_dc), 32'd1);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        RST_N = 1;
        @(posedge SYSTEM_CLK);
        #1;

        // Two back-to-back single-byte commands: setup, hold and gap framing.
        mode = 0; busy_max = 0;
        c[0] = 8'h11; send_cmd(1, c, 0); exp_cmd(1, c);
        c[0] = 8'h22; send_cmd(1, c, 0); exp_cmd(1, c);
        wait_quiet();
        check("setup_cycles", 32'(setup_last), 32'(SETUP));
        check("hold_after_last", 32'(hold_last), 32'(1 + HOLD));     // one DRAIN cycle, then HOLD
        check("gap_cycles", 32'(gap_last), 32'(GAP + 1));           // GAP, then the IDLE decision cycle
        compare_stream("cmd_pair");

        // Simultaneous requests: command first, then the new frame with RAMWR.
        win_grant_q.delete();
        c[0] = 8'h2A; b[0] = 8'h12; b[1] = 8'h34;
        fork
            send_cmd(1, c, 0);
            send_frame(2, b, 0);
        join
        exp_cmd(1, c); exp_frame(0, 2, b, 8'h2C);
        wait_quiet();
        check("prio_first_grant", 32'(win_grant_q.size() > 0 ? win_grant_q[0] : 2'b11), 32'd1);
        check("prio_second_grant", 32'(win_grant_q.size() > 1 ? win_grant_q[1] : 2'b11), 32'd2);
        compare_stream("prio");

        // Toggling ready; then a stray pixel byte must be consumed as an error.
        mode = 1;
        b[0] = 8'hA5; b[1] = 8'h5A; b[2] = 8'hFF; b[3] = 8'h00;
        send_frame(4, b, 0); exp_frame(0, 4, b, 8'h2C);
        wait_quiet();
        compare_stream("toggle_frame");
        w0 = windows; e0 = err_cnt;
        send_byte(1, 8'h33, 0, 0, e);
        repeat (3) @(posedge SYSTEM_CLK);
        #1;
        check("orphan_err", 32'(e), 32'd1);
        check("orphan_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("orphan_cs_high", 32'(windows - w0), 32'd0);
        check("orphan_no_tx", 32'(got_q.size()), 32'd0);

`ifdef ST7735_ARB_BURST_LIMIT_EN
        // Burst limit: command raised after two pixel bytes takes over after byte 4.
        mode = 0; busy_max = 0;
        w0 = windows; base = pix_sent;
        for (int i = 0; i < 12; i++) b[i] = 8'(8'h40 + i);
        c[0] = 8'h2A;
        fork
            send_frame(12, b, 0);
            begin
                for (int i = 0; i < 200 && pix_sent < base + 2; i++) @(negedge SYSTEM_CLK);
                @(posedge SYSTEM_CLK);
                #1;
                send_cmd(1, c, 0);
            end
        join
        exp_frame(0, 4, b, 8'h2C); exp_cmd(1, c); exp_frame(4, 12, b, 8'h3C);
        wait_quiet();
        check("burst_windows", 32'(windows - w0), 32'd3);
        compare_stream("burst");
`endif

        // Random sequence of commands and frames under varied serializer behaviour.
        w0 = windows;
        for (int t = 0; t < 20; t++) begin
            mode = $urandom_range(2, 0);
            busy_max = $urandom_range(3, 0);
            for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                n = 2 * $urandom_range(5, 1);
                send_frame(n, b, 1); exp_frame(0, n, b, 8'h2C);
            end else begin
                n = $urandom_range(4, 1);
                send_cmd(n, b, 1); exp_cmd(n, b);
            end
            idle_gap(1);
        end
        wait_quiet();
        check("rand_windows", 32'(windows - w0), 32'd20);
        compare_stream("rand");

        // Reset in the middle of a frame aborts at once and forgets the open frame.
        mode = 0; busy_max = 0;
        pix_valid = 1; pix_data = 8'h77; pix_first = 1; pix_last = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge SYSTEM_CLK);
            if (pix_ready) break;
        end
        RST_N = 0;
        #1;
        check("mid_rst_cs", 32'(LCD_CS), 32'd1);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        pix_valid = 0;
        repeat (2) @(posedge SYSTEM_CLK);
        #1;
        RST_N = 1;
        got_q.delete(); exp_q.delete();
        @(posedge SYSTEM_CLK);
        #1;
        send_byte(1, 8'h55, 0, 0, e);
        check("post_rst_err", 32'(e), 32'd1);

        repeat (4) @(posedge SYSTEM_CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/st7735_bus_arbiter.md
Name: st7735_bus_arbiter

Overview:
- Shares the single ST7735 SPI byte serializer between two requesters: a command/config channel (init sequence, CASET/RASET, etc.) and a pixel stream channel (RGB565 bytes).
- Owns LCD chip-select framing and the D/C bit per byte.
- Inserts RAMWR (0x2C) at frame start and RAMWRC (0x3C) when a preempted frame resumes.
- Sits between the init/cursor sequencer, the pixel source, and the SPI byte transmitter.

Parameters:
- CS_SETUP_CYCLES, 2: cycles LCD_CS is low before the first byte is offered.
- CS_HOLD_CYCLES, 2: cycles after serializer idle before LCD_CS rises.
- CS_GAP_CYCLES, 4: minimum cycles LCD_CS stays high between transactions.
- MAX_PIX_BURST, 256: pixel bytes per grant before a yield to a pending command. Must be even; used only with the optional feature.

Ports:
- SYSTEM_CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command byte valid
- cmd_data  in  8  command byte
- cmd_dc  in  1  D/C for this byte (0 = command, 1 = parameter)
- cmd_last  in  1  last byte of command transaction
- cmd_ready  out  1  command byte accepted this cycle
- pix_valid  in  1  pixel byte valid
- pix_data  in  8  pixel byte (MSB byte first per pixel)
- pix_first  in  1  first byte of a frame
- pix_last  in  1  last byte of a frame
- pix_ready  out  1  pixel byte accepted this cycle
- tx_valid  out  1  byte offered to serializer
- tx_data  out  8  byte to serializer
- tx_dc  out  1  D/C to drive with this byte
- tx_ready  in  1  serializer accepts byte
- tx_idle  in  1  serializer shift register empty
- LCD_CS  out  1  panel chip select, active low
- grant  out  2  01 = cmd, 10 = pix, 00 = none
- err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset values: LCD_CS=1, tx_valid=0, tx_data=0, tx_dc=1, cmd_ready=0, pix_ready=0, grant=00, err=0. Internal state: frame_open=0, counters=0, state IDLE.
- Reset asserted mid-transaction aborts immediately. frame_open is cleared; the next pixel frame must restart with pix_first.
- States: IDLE -> SETUP -> (PREFIX) -> STREAM -> DRAIN -> HOLD -> GAP -> IDLE.
- IDLE:
  - cmd_valid has priority over pix_valid; when both are asserted in the same cycle, cmd wins.
  - The grant is latched for the whole transaction.
  - Pixel grant with pix_first=1, or with frame_open=1, goes to SETUP.
  - pix_valid with pix_first=0 and frame_open=0 is a protocol error: consume the byte (pix_ready=1 for one cycle), pulse err, stay in IDLE.
- SETUP: LCD_CS=0, count CS_SETUP_CYCLES. Cmd grant -> STREAM; pix grant -> PREFIX.
- PREFIX:
  - tx_valid=1, tx_dc=0, tx_data=0x2C if the granted byte has pix_first=1, else 0x3C.
  - On tx_ready: go to STREAM and set frame_open=1.
- STREAM:
  - tx_valid mirrors the granted valid; tx_data/tx_dc come from the granted port (pix: tx_dc=1).
  - The granted ready equals tx_ready & granted valid. The ungranted ready is 0.
  - The transaction ends when a byte with last=1 is accepted; on a pix_last accept, clear frame_open. Then -> DRAIN.
- DRAIN: tx_valid=0; wait for tx_idle=1, then -> HOLD.
- HOLD: count CS_HOLD_CYCLES, then LCD_CS=1 and -> GAP.
- GAP: count CS_GAP_CYCLES, then -> IDLE, grant=00.
- Counters are sized with $clog2 of the largest parameter plus 1 bit. Counters saturate, never wrap.
- Bytes in STREAM are never dropped or duplicated. The requester may hold valid low mid-transaction; LCD_CS stays low while it does.

Optional Feature:
- Macro: ST7735_ARB_BURST_LIMIT_EN.
- Enabled:
  - Pixel grants count accepted bytes.
  - When the count reaches MAX_PIX_BURST and cmd_valid=1, the pixel transaction ends after that byte (always on a pixel boundary) -> DRAIN. frame_open stays 1.
  - The command transaction runs next. The pixel stream resumes later with a 0x3C prefix.
  - The count resets on every new grant.
- Disabled: pixel transactions run to pix_last, and commands wait.

Test Plan:
- Cmd 0x11 (dc=0, last=1) with tx_ready tied 1 -> LCD_CS low for 2 cycles before tx_valid; tx_data=0x11, tx_dc=0; LCD_CS rises 2 cycles after tx_idle; 4 gap cycles before the next grant.
- cmd_valid and pix_valid (pix_first=1) in the same IDLE cycle -> grant=01 first. Pixel transaction then emits 0x2C (dc=0), followed by pixel bytes with dc=1.
- Pixel frame of 4 bytes A5,5A,FF,00 with tx_ready toggling every cycle -> exactly 0x2C,A5,5A,FF,00 on tx_data; frame_open=0 after the last byte.
- pix_valid with pix_first=0 and no open frame -> err pulses once, pix_ready pulses once, LCD_CS stays 1.
- With ST7735_ARB_BURST_LIMIT_EN, MAX_PIX_BURST=4, a 12-byte frame, and cmd 0x2A raised at pixel byte 2 -> sequence 0x2C,b0..b3 | 0x2A | 0x3C,b4..b11; LCD_CS toggles high between each transaction.
- RST_N asserted during STREAM -> same cycle LCD_CS=1, tx_valid=0; the next pixel byte without pix_first flags err.
